// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and small helpers for the video path.
package vga_pkg;

    // Coordinate counter width; 799 and 524 both fit.
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Pixel clock divider from the 100 MHz board clock.
    localparam int CLK_DIV_DEF = 4;

    // Horizontal timing in pixels.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing in lines.
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulse windows (inclusive bounds).
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Asserted sync level; 0 means active-low.
    localparam logic SYNC_POL_DEF = 1'b0;

    // True when lo <= v <= hi.
    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel clock enable: one-clk strobe every CLK_DIV board clocks.
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixelTick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_nxt;
    logic          r_tick;

    // Next divider value, wrapping at CLK_DIV-1.
    always_comb begin
        w_div_nxt = r_div_cnt;
        if (r_div_cnt == DIV_LAST) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div_cnt + DW'(1);
        end
    end

    // Divider register; the strobe is registered from the next count so it
    // is high exactly while the divider register holds CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_tick    <= (w_div_nxt == DIV_LAST);
        end
    end

    assign pixelTick = r_tick;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel coordinates, blanking, syncs and frame strobe.
// hsync/vsync lag x/y by one clk to line up with the renderer's rgb register.
module vga_sync
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             videoOn,
    output logic             hsync,
    output logic             vsync,
    output logic             pixelTick,
    output logic             frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t X_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t Y_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t X_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t Y_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic w_tick;
    cnt_t r_x;
    cnt_t r_y;
    cnt_t w_x_nxt;
    cnt_t w_y_nxt;
    logic w_wrap;
    logic w_video_nxt;
    logic w_hs_act;
    logic w_vs_act;
    logic r_video_on;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixelTick (w_tick)
    );

    // Next coordinates: advance x on a pixel tick, carry into y, wrap the frame.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_wrap  = 1'b0;
        if (w_tick) begin
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                if (r_y == Y_LAST) begin
                    w_y_nxt = '0;
                    w_wrap  = 1'b1;
                end else begin
                    w_y_nxt = r_y + cnt_t'(1);
                end
            end else begin
                w_x_nxt = r_x + cnt_t'(1);
            end
        end else begin
            w_x_nxt = r_x;
            w_y_nxt = r_y;
        end
    end

    // Decodes: blanking from the next coordinates, syncs from the current ones.
    always_comb begin
        w_video_nxt = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
        w_hs_act    = in_window(r_x, HS_START, HS_END);
        w_vs_act    = in_window(r_y, VS_START, VS_END);
    end

    // Coordinate counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_video_on    <= w_video_nxt;
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_wrap;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign videoOn    = r_video_on;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign pixelTick  = w_tick;
    assign frameStart = r_frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Directed self-checking bench for vga_sync.
// dut0: default 640x480 timing, CLK_DIV=4, active-low syncs.
// dut1: CLK_DIV=2, SYNC_POL=1, full-width lines but an 8-line frame so
//       frame wrap and vsync can be reached in a short run.
`timescale 1ns/1ps
module tb_vga_sync;

    logic       clk = 1'b0;
    logic       rst0_n = 1'b0;
    logic       rst1_n = 1'b0;

    logic [9:0] x0, y0, x1, y1;
    logic       vo0, hs0, vs0, pt0, fs0;
    logic       vo1, hs1, vs1, pt1, fs1;

    int errs = 0;
    int chks = 0;
    int cyc0 = 0;
    int cyc1 = 0;
    int fs_cnt0 = 0;
    int fs_cnt1 = 0;
    int fs_last1 = -1;

    always #5 clk = ~clk;

    vga_sync dut0 (
        .clk        (clk),
        .rst_n      (rst0_n),
        .x          (x0),
        .y          (y0),
        .videoOn    (vo0),
        .hsync      (hs0),
        .vsync      (vs0),
        .pixelTick  (pt0),
        .frameStart (fs0)
    );

    vga_sync #(
        .CLK_DIV  (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .x          (x1),
        .y          (y1),
        .videoOn    (vo1),
        .hsync      (hs1),
        .vsync      (vs1),
        .pixelTick  (pt1),
        .frameStart (fs1)
    );

    // Count one comparison and report it when observed != expected.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One dut0 clock: sample after the falling edge, count frameStart pulses.
    task automatic step0();
        @(posedge clk);
        @(negedge clk);
        cyc0++;
        if (fs0) fs_cnt0++;
    endtask

    task automatic run0(input int c);
        while (cyc0 < c) step0();
    endtask

    task automatic step1();
        @(posedge clk);
        @(negedge clk);
        cyc1++;
        if (fs1) begin
            fs_cnt1++;
            fs_last1 = cyc1;
        end
    endtask

    task automatic run1(input int c);
        while (cyc1 < c) step1();
    endtask

    // dut0 behaviour right after a reset release (cyc0 = 0, no edge yet).
    task automatic startup0(input string pfx);
        check({pfx, "_vo_c0"}, vo0, 0);
        check({pfx, "_x_c0"}, x0, 0);
        for (int k = 1; k <= 8; k++) begin
            step0();
            check({pfx, "_tick"}, pt0, ((cyc0 % 4) == 3) ? 1 : 0);
            check({pfx, "_x"}, x0, cyc0 / 4);
            check({pfx, "_y"}, y0, 0);
            check({pfx, "_vo"}, vo0, 1);
            check({pfx, "_hs"}, hs0, 1);
        end
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst0_x", x0, 0);
        check("rst0_y", y0, 0);
        check("rst0_vo", vo0, 0);
        check("rst0_hs", hs0, 1);
        check("rst0_vs", vs0, 1);
        check("rst0_tick", pt0, 0);
        check("rst0_fs", fs0, 0);
        check("rst1_hs", hs1, 0);
        check("rst1_vs", vs1, 0);
        check("rst1_tick", pt1, 0);

        // ---------------- dut0: startup and line timing ----------------
        rst0_n = 1'b1;
        cyc0 = 0;
        fs_cnt0 = 0;
        startup0("start");

        run0(2559);
        check("x639", x0, 639);
        check("vo_at_639", vo0, 1);
        run0(2560);
        check("x640", x0, 640);
        check("vo_at_640", vo0, 0);
        run0(2624);
        check("x656", x0, 656);
        check("hs_before_fall", hs0, 1);
        run0(2625);
        check("hs_fall", hs0, 0);
        run0(3008);
        check("x752", x0, 752);
        check("hs_still_low", hs0, 0);
        run0(3009);
        check("hs_rise", hs0, 1);
        run0(3199);
        check("x799", x0, 799);
        check("tick_799", pt0, 1);
        check("y_line0", y0, 0);
        run0(3200);
        check("line_wrap_x", x0, 0);
        check("line_wrap_y", y0, 1);
        check("line_wrap_vo", vo0, 1);
        check("vs_idle", vs0, 1);

        // ---------------- dut0: mid-frame reset ----------------
        run0(4400);
        check("mid_x", x0, 300);
        check("mid_y", y0, 1);
        rst0_n = 1'b0;
        #1;
        check("mid_rst_x", x0, 0);
        check("mid_rst_y", y0, 0);
        check("mid_rst_vo", vo0, 0);
        check("mid_rst_hs", hs0, 1);
        check("mid_rst_tick", pt0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_hold_x", x0, 0);
        check("mid_hold_tick", pt0, 0);
        rst0_n = 1'b1;
        cyc0 = 0;
        fs_cnt0 = 0;
        startup0("restart");
        run0(3200);
        check("restart_x", x0, 0);
        check("restart_y", y0, 1);
        check("restart_no_fs", fs_cnt0, 0);

        // ---------------- dut1: CLK_DIV=2, SYNC_POL=1, 8-line frame ----------------
        rst1_n = 1'b1;
        cyc1 = 0;
        fs_cnt1 = 0;
        check("p_vo_c0", vo1, 0);
        step1();
        check("p_tick_c1", pt1, 1);
        check("p_x_c1", x1, 0);
        check("p_vo_c1", vo1, 1);
        step1();
        check("p_tick_c2", pt1, 0);
        check("p_x_c2", x1, 1);
        step1();
        check("p_tick_c3", pt1, 1);
        run1(1312);
        check("p_x656", x1, 656);
        check("p_hs_idle", hs1, 0);
        run1(1313);
        check("p_hs_pulse", hs1, 1);
        run1(1504);
        check("p_x752", x1, 752);
        check("p_hs_still", hs1, 1);
        run1(1505);
        check("p_hs_end", hs1, 0);
        run1(1600);
        check("p_line_x", x1, 0);
        check("p_line_y", y1, 1);
        run1(6399);
        check("p_x_last_act", x1, 799);
        check("p_y_last_act", y1, 3);
        run1(6400);
        check("p_y4", y1, 4);
        check("p_vo_y4", vo1, 0);
        run1(8000);
        check("p_y5", y1, 5);
        check("p_vs_idle", vs1, 0);
        run1(8001);
        check("p_vs_pulse", vs1, 1);
        run1(11200);
        check("p_y7", y1, 7);
        check("p_vs_still", vs1, 1);
        run1(11201);
        check("p_vs_end", vs1, 0);
        run1(12799);
        check("p_wrap_x", x1, 799);
        check("p_wrap_y", y1, 7);
        check("p_wrap_tick", pt1, 1);
        check("p_no_fs_yet", fs_cnt1, 0);
        run1(12800);
        check("p_frame_x", x1, 0);
        check("p_frame_y", y1, 0);
        check("p_frame_fs", fs1, 1);
        check("p_frame_vo", vo1, 1);
        run1(12801);
        check("p_fs_drop", fs1, 0);
        run1(25601);
        check("p_fs_count", fs_cnt1, 2);
        check("p_fs_last", fs_last1, 25600);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
